// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the execute-stage hazard controller: register index
// width and the stall/forward sequencer state encoding.
package hazard_ctrl_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL_A = 2'b01,
        FWD     = 2'b10,
        STALL_B = 2'b11
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// Qualified load-use compare: a source operand that is actually read matches
// the destination of a register-writing load in EX.
module reg_match
    import hazard_ctrl_pkg::*;
(
    input  logic             use_src,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] dst,
    output logic             match
);

    assign match = use_src & ex_memread & ex_regwrite & (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall sequencer with operand-A forward and branch squash for the
// IF/ID and ID/EX pipeline registers.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             PCSrc_cntrl,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             Load_warning,
    output logic [CNT_W-1:0] stall_count
);

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic             hz_a;
    logic             hz_b;
    logic             stall;
    logic             flush;
    logic             load_warning_q;
    logic [CNT_W-1:0] stall_count_q;

    reg_match u_match_rs (
        .use_src     (id_uses_rs),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .src         (id_rs),
        .dst         (ex_rd),
        .match       (hz_a)
    );

    reg_match u_match_rt (
        .use_src     (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .src         (id_rt),
        .dst         (ex_rd),
        .match       (hz_b)
    );

    // FWD behaves like RUN for detection so back-to-back loads lose no cycle.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN, FWD: begin
                state_d = RUN;
                if (PCSrc_cntrl) begin
                    flush = 1'b1;
                end else if (hz_b) begin
                    stall   = 1'b1;
                    state_d = STALL_B;
                end else if (hz_a) begin
                    stall   = 1'b1;
                    state_d = STALL_A;
                end
            end
            STALL_A: begin
                if (PCSrc_cntrl) begin
                    flush   = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = FWD;
                end
            end
            STALL_B: begin
                state_d = RUN;
                if (PCSrc_cntrl) begin
                    flush = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    assign pc_hold     = stall;
    assign ifid_hold   = stall;
    assign idex_bubble = stall | flush;
    assign ifid_flush  = flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            load_warning_q <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            load_warning_q <= (state_d == FWD);
            if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign Load_warning = load_warning_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a schedule-based
// reference model of stall, forward and squash cycles.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       r;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic [2:0] rd;
        logic       rw;
        logic       mr;
        logic       pc;
    } stim_t;

    typedef enum int {K_QUIET, K_HOLD, K_FWD} kind_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [2:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic       ex_regwrite = 1'b0, ex_memread = 1'b0, PCSrc_cntrl = 1'b0;

    logic        pc_hold, ifid_hold, idex_bubble, ifid_flush, Load_warning;
    logic [15:0] stall_count;
    logic        s_pc_hold, s_ifid_hold, s_idex_bubble, s_ifid_flush, s_Load_warning;
    logic [3:0]  s_stall_count;
    wire  [4:0]  got = {pc_hold, ifid_hold, idex_bubble, ifid_flush, Load_warning};

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .PCSrc_cntrl(PCSrc_cntrl),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .Load_warning(Load_warning), .stall_count(stall_count)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .PCSrc_cntrl(PCSrc_cntrl),
        .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .idex_bubble(s_idex_bubble),
        .ifid_flush(s_ifid_flush), .Load_warning(s_Load_warning), .stall_count(s_stall_count)
    );

    kind_t      q[$];
    kind_t      nq[$];
    int         cnt16 = 0, cnt4 = 0, ncnt16 = 0, ncnt4 = 0;
    logic [4:0] exp_out;
    int         tests_run = 0;
    int         fails = 0;

    localparam stim_t IDLE   = '{r:0, rs:0, rt:0, urs:0, urt:0, rd:0, rw:0, mr:0, pc:0};
    localparam stim_t RST    = '{r:1, rs:0, rt:0, urs:0, urt:0, rd:0, rw:0, mr:0, pc:0};
    localparam stim_t LD3_RS = '{r:0, rs:3, rt:1, urs:1, urt:0, rd:3, rw:1, mr:1, pc:0};
    localparam stim_t LD5_RT = '{r:0, rs:5, rt:5, urs:1, urt:1, rd:5, rw:1, mr:1, pc:0};

    // Each cycle of the upcoming schedule is either quiet, a forced hold, or a
    // forward cycle in which new loads may again be detected.
    task automatic model_eval(input stim_t s);
        bit    free, hza, hzb, hold, flush, bub, lw;
        kind_t k;
        nq   = q;
        free = (q.size() == 0);
        lw   = (q.size() > 0) && (q[0] == K_FWD);
        k    = K_QUIET;
        if (!free) begin
            k = q[0];
            void'(nq.pop_front());
            if (k == K_FWD) free = 1;
        end
        hza = s.mr && s.rw && s.urs && (s.rs == s.rd);
        hzb = s.mr && s.rw && s.urt && (s.rt == s.rd);
        hold = 0; flush = 0; bub = 0;
        if (s.r) begin
            nq.delete();
        end else if (s.pc) begin
            flush = 1; bub = 1;
            nq.delete();
        end else if (!free) begin
            if (k == K_HOLD) begin hold = 1; bub = 1; end
        end else if (hzb) begin
            hold = 1; bub = 1;
            nq.push_back(K_HOLD);
        end else if (hza) begin
            hold = 1; bub = 1;
            nq.push_back(K_QUIET);
            nq.push_back(K_FWD);
        end
        exp_out = {hold, hold, bub, flush, lw};
        if (s.r) begin
            ncnt16 = 0; ncnt4 = 0;
        end else begin
            ncnt16 = (hold && cnt16 < 65535) ? cnt16 + 1 : cnt16;
            ncnt4  = (hold && cnt4 < 15) ? cnt4 + 1 : cnt4;
        end
    endtask

    task automatic drive(input stim_t s);
        @(posedge clk);
        q = nq; cnt16 = ncnt16; cnt4 = ncnt4;
        #1;
        rst = s.r; id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
        ex_rd = s.rd; ex_regwrite = s.rw; ex_memread = s.mr; PCSrc_cntrl = s.pc;
        @(negedge clk);
        model_eval(s);
    endtask

    task automatic test_reset();
        drive(RST);
        drive(RST);
        tests_run++;
        if (got !== 5'b0 || stall_count !== 16'd0) begin
            fails++;
            $display("FAIL reset: outputs=%b count=%0d, required 00000 / 0", got, stall_count);
        end
    endtask

    task automatic test_rs_hazard();
        stim_t seq[5] = '{LD3_RS, IDLE, IDLE, IDLE, IDLE};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            tests_run++;
            if (got !== exp_out || stall_count !== 16'(cnt16)) begin
                fails++;
                $display("FAIL rs_hazard cyc%0d: got %b/%0d, required %b/%0d", i, got, stall_count, exp_out, cnt16);
            end
            if (i == 2) begin
                tests_run++;
                if (Load_warning !== 1'b1 || stall_count !== 16'd1) begin
                    fails++;
                    $display("FAIL rs_forward: Load_warning=%b count=%0d, required 1 / 1", Load_warning, stall_count);
                end
            end
        end
    endtask

    task automatic test_rt_hazard();
        stim_t seq[5] = '{RST, LD5_RT, IDLE, IDLE, IDLE};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            tests_run++;
            if (got !== exp_out || stall_count !== 16'(cnt16)) begin
                fails++;
                $display("FAIL rt_hazard cyc%0d: got %b/%0d, required %b/%0d", i, got, stall_count, exp_out, cnt16);
            end
        end
        tests_run++;
        if (stall_count !== 16'd2) begin
            fails++;
            $display("FAIL rt_count: count=%0d, required 2", stall_count);
        end
    endtask

    task automatic test_no_stall();
        stim_t seq[5];
        seq[0] = '{r:0, rs:2, rt:0, urs:0, urt:0, rd:2, rw:1, mr:1, pc:0};
        seq[1] = '{r:0, rs:2, rt:0, urs:1, urt:0, rd:2, rw:0, mr:1, pc:0};
        seq[2] = '{r:0, rs:2, rt:2, urs:1, urt:1, rd:2, rw:1, mr:0, pc:0};
        seq[3] = '{r:0, rs:2, rt:4, urs:1, urt:1, rd:6, rw:1, mr:1, pc:0};
        seq[4] = IDLE;
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            tests_run++;
            if (got !== exp_out || got !== 5'b0) begin
                fails++;
                $display("FAIL no_stall cyc%0d: got %b, required %b", i, got, exp_out);
            end
        end
    endtask

    task automatic test_flush();
        stim_t fl_a = LD3_RS;
        stim_t seq[8];
        fl_a.pc = 1'b1;
        seq = '{fl_a, IDLE, IDLE, IDLE, LD5_RT, '{r:0, rs:0, rt:0, urs:0, urt:0, rd:0, rw:0, mr:0, pc:1}, IDLE, IDLE};
        for (int i = 0; i < 8; i++) begin
            drive(seq[i]);
            tests_run++;
            if (got !== exp_out) begin
                fails++;
                $display("FAIL flush cyc%0d: got %b, required %b", i, got, exp_out);
            end
            if (i == 0) begin
                tests_run++;
                if (got !== 5'b00110) begin
                    fails++;
                    $display("FAIL flush_vs_hz_a: got %b, required 00110", got);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        stim_t seq[5] = '{LD3_RS, RST, IDLE, IDLE, IDLE};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            tests_run++;
            if (got !== exp_out || stall_count !== 16'(cnt16)) begin
                fails++;
                $display("FAIL rst_mid cyc%0d: got %b/%0d, required %b/%0d", i, got, stall_count, exp_out, cnt16);
            end
            if (i >= 2) begin
                tests_run++;
                if (got !== 5'b0 || stall_count !== 16'd0) begin
                    fails++;
                    $display("FAIL rst_mid_clear cyc%0d: got %b/%0d, required 00000/0", i, got, stall_count);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t seq[9] = '{RST, LD3_RS, IDLE, LD5_RT, IDLE, LD3_RS, IDLE, IDLE, IDLE};
        for (int i = 0; i < 9; i++) begin
            drive(seq[i]);
            tests_run++;
            if (got !== exp_out || stall_count !== 16'(cnt16)) begin
                fails++;
                $display("FAIL back_to_back cyc%0d: got %b/%0d, required %b/%0d", i, got, stall_count, exp_out, cnt16);
            end
        end
    endtask

    task automatic test_saturation();
        drive(RST);
        for (int i = 0; i < 14; i++) drive(LD5_RT);
        for (int h = 0; h < 3; h++) begin
            drive(IDLE);
            drive(LD5_RT);
            drive(IDLE);
            tests_run++;
            if (s_stall_count !== 4'(cnt4) || stall_count !== 16'(cnt16)) begin
                fails++;
                $display("FAIL saturation hz%0d: got %0d/%0d, required %0d/%0d", h, s_stall_count, stall_count, cnt4, cnt16);
            end
        end
        drive(IDLE);
        tests_run++;
        if (s_stall_count !== 4'hF || stall_count !== 16'd20) begin
            fails++;
            $display("FAIL saturation_final: got %0d/%0d, required 15/20", s_stall_count, stall_count);
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 3000; i++) begin
            s.r   = ($urandom_range(0, 99) < 2);
            s.rs  = 3'($urandom_range(0, 3));
            s.rt  = 3'($urandom_range(0, 3));
            s.rd  = 3'($urandom_range(0, 3));
            s.urs = ($urandom_range(0, 3) != 0);
            s.urt = ($urandom_range(0, 1) != 0);
            s.rw  = ($urandom_range(0, 3) != 0);
            s.mr  = ($urandom_range(0, 3) != 0);
            s.pc  = ($urandom_range(0, 9) == 0);
            drive(s);
            tests_run++;
            if (got !== exp_out || stall_count !== 16'(cnt16) || s_stall_count !== 4'(cnt4)) begin
                fails++;
                $display("FAIL random cyc%0d: got %b/%0d/%0d, required %b/%0d/%0d",
                         i, got, stall_count, s_stall_count, exp_out, cnt16, cnt4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rs_hazard();
        test_rt_hazard();
        test_no_stall();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
